// File: rtl/pixel_unpacker_if.sv
// Stream bundle for pixel_unpacker: the wide beat-side handshake from the
// processing path and the serial pixel-side handshake to the video sink.
interface pixel_unpacker_if #(
  parameter int BITS         = 8,
  parameter int N_PIX        = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);

  // Beat side
  logic [N_PIX-1:0][BITS-1:0] pix_in;
  logic                       valid_in;
  logic                       sof_in;
  logic                       module_ready;

  // Serial side
  logic [BITS-1:0]            pix_out;
  logic                       valid_out;
  logic                       output_ready;
  logic [XW-1:0]              pixel_x;
  logic [YW-1:0]              pixel_y;
  logic                       sop_out;
  logic                       eop_out;
  logic                       sync_error;

  // Environment view: produces beats and consumes serial pixels
  modport master (
    output pix_in, valid_in, sof_in, output_ready,
    input  module_ready, pix_out, valid_out, pixel_x, pixel_y,
           sop_out, eop_out, sync_error
  );

  // Unpacker view
  modport slave (
    input  pix_in, valid_in, sof_in, output_ready,
    output module_ready, pix_out, valid_out, pixel_x, pixel_y,
           sop_out, eop_out, sync_error
  );
endinterface

// File: rtl/pixel_unpacker.sv
// Parallel-to-serial pixel converter: buffers one N_PIX-wide beat, replays it
// one pixel per clock, and regenerates raster coordinates and frame markers.
module pixel_unpacker #(
  parameter int BITS         = 8,
  parameter int N_PIX        = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input logic             clk,
  input logic             reset,
  pixel_unpacker_if.slave bus
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam int IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                     state;
  logic [N_PIX-1:0][BITS-1:0] beat_buf;
  logic [IW-1:0]              idx;
  logic [XW-1:0]              x;
  logic [YW-1:0]              y;
  logic                       sync_error_q;

  logic                       advance;
  logic                       last_pix;
  logic                       ready;
  logic                       load;
  logic [XW-1:0]              x_adv;
  logic [YW-1:0]              y_adv;

  assign advance  = (state == DRAIN) && bus.output_ready;
  assign last_pix = (idx == IW'(N_PIX - 1));
  assign ready    = (state == EMPTY) || (advance && last_pix);
  assign load     = bus.valid_in && ready;

  // Raster position after this cycle's serial handshake (x,y unchanged if none)
  always_comb begin
    x_adv = x;
    y_adv = y;
    if (advance) begin
      if (x == XW'(IMAGE_WIDTH - 1)) begin
        x_adv = '0;
        y_adv = (y == YW'(IMAGE_HEIGHT - 1)) ? '0 : y + YW'(1);
      end else begin
        x_adv = x + XW'(1);
      end
    end
  end

  // Beat buffer, drain index, raster counters and EMPTY/DRAIN control.
  // The sof check uses the post-advance position so a beat loaded on the
  // last-pixel handshake of a frame is correctly seen as landing on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= EMPTY;
      beat_buf     <= '0;
      idx          <= '0;
      x            <= '0;
      y            <= '0;
      sync_error_q <= 1'b0;
    end else begin
      sync_error_q <= 1'b0;
      if (load) begin
        beat_buf <= bus.pix_in;
        idx      <= '0;
        state    <= DRAIN;
        if (bus.sof_in) begin
          x            <= '0;
          y            <= '0;
          sync_error_q <= (x_adv != '0) || (y_adv != '0);
        end else begin
          x <= x_adv;
          y <= y_adv;
        end
      end else begin
        x <= x_adv;
        y <= y_adv;
        if (advance) begin
          if (last_pix) begin
            idx   <= '0;
            state <= EMPTY;
          end else begin
            idx <= idx + IW'(1);
          end
        end
      end
    end
  end

  assign bus.module_ready = ready;
  assign bus.pix_out      = beat_buf[idx];
  assign bus.valid_out    = (state == DRAIN);
  assign bus.pixel_x      = x;
  assign bus.pixel_y      = y;
  assign bus.sop_out      = (state == DRAIN) && (x == '0) && (y == '0);
  assign bus.eop_out      = (state == DRAIN) && (x == XW'(IMAGE_WIDTH - 1)) &&
                            (y == YW'(IMAGE_HEIGHT - 1));
  assign bus.sync_error   = sync_error_q;
endmodule

// File: tb/tb_pixel_unpacker.sv
// Testbench for pixel_unpacker: a reduced image size keeps full frames short.
// Expected pixels come from a queue filled at beat acceptance, with positions
// derived from a running pixel count within the frame.
module tb_pixel_unpacker;
  localparam int BITS   = 8;
  localparam int N_PIX  = 8;
  localparam int W      = 32;
  localparam int H      = 6;
  localparam int FRAME  = W * H;
  localparam int TARGET = 5 * W + W / 2;

  typedef logic [N_PIX-1:0][BITS-1:0] beat_t;

  typedef struct {
    int  pix;
    int  x;
    int  y;
    bit  sop;
    bit  eop;
  } exp_pix_t;

  logic clk;
  logic reset;

  pixel_unpacker_if #(
    .BITS(BITS), .N_PIX(N_PIX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) bus ();

  pixel_unpacker #(
    .BITS(BITS), .N_PIX(N_PIX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_pix_t q[$];
  int       next_pos;
  bit       exp_sync;
  bit       last_load;
  int       num_checks;
  int       num_fail;
  int       dut_eop_count;
  int       model_eop_count;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input int actual, input int expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic beat_t randomBeat();
    beat_t b;
    for (int i = 0; i < N_PIX; i++) b[i] = BITS'($urandom);
    return b;
  endfunction

  // One clock of stimulus: drive after the falling edge, check outputs against
  // the model, then update the model for the handshakes at the next rising edge
  task automatic applyStimulus(input bit vin, input bit sof, input bit rdy, input beat_t beat);
    bit exp_valid;
    bit exp_ready;
    @(negedge clk);
    bus.valid_in     = vin;
    bus.sof_in       = sof;
    bus.output_ready = rdy;
    bus.pix_in       = beat;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && rdy);
    checkOutput("valid_out", int'(bus.valid_out), int'(exp_valid));
    checkOutput("module_ready", int'(bus.module_ready), int'(exp_ready));
    checkOutput("sync_error", int'(bus.sync_error), int'(exp_sync));
    exp_sync = 1'b0;
    if (q.size() != 0) begin
      checkOutput("pix_out", int'(bus.pix_out), q[0].pix);
      checkOutput("pixel_x", int'(bus.pixel_x), q[0].x);
      checkOutput("pixel_y", int'(bus.pixel_y), q[0].y);
      checkOutput("sop_out", int'(bus.sop_out), int'(q[0].sop));
      checkOutput("eop_out", int'(bus.eop_out), int'(q[0].eop));
    end
    if (bus.valid_out && rdy && bus.eop_out) dut_eop_count++;
    if (q.size() != 0 && rdy) begin
      if (q[0].eop) model_eop_count++;
      void'(q.pop_front());
    end
    last_load = vin && exp_ready;
    if (last_load) begin
      if (sof) begin
        exp_sync = (next_pos != 0);
        next_pos = 0;
      end
      for (int i = 0; i < N_PIX; i++) begin
        q.push_back('{pix: int'(beat[i]), x: next_pos % W, y: next_pos / W,
                      sop: (next_pos == 0), eop: (next_pos == FRAME - 1)});
        next_pos = (next_pos + 1) % FRAME;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " valid_out"}, int'(bus.valid_out), 0);
    checkOutput({tag, " sop_out"}, int'(bus.sop_out), 0);
    checkOutput({tag, " eop_out"}, int'(bus.eop_out), 0);
    checkOutput({tag, " sync_error"}, int'(bus.sync_error), 0);
    checkOutput({tag, " pix_out"}, int'(bus.pix_out), 0);
    checkOutput({tag, " pixel_x"}, int'(bus.pixel_x), 0);
    checkOutput({tag, " pixel_y"}, int'(bus.pixel_y), 0);
    checkOutput({tag, " module_ready"}, int'(bus.module_ready), 1);
  endtask

  // Drain the model queue with output_ready high, bounded in cycles
  task automatic drainAll();
    for (int c = 0; c < 4 * N_PIX && q.size() != 0; c++)
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("drain empty", q.size(), 0);
  endtask

  initial begin
    beat_t b;
    bit    done;
    num_checks      = 0;
    num_fail        = 0;
    next_pos        = 0;
    exp_sync        = 1'b0;
    last_load       = 1'b0;
    dut_eop_count   = 0;
    model_eop_count = 0;
    reset            = 1'b0;
    bus.valid_in     = 1'b0;
    bus.sof_in       = 1'b0;
    bus.output_ready = 1'b0;
    bus.pix_in       = '0;

    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b1;

    $display("[TB] directed beat 0x10..0x17 with sof");
    for (int i = 0; i < N_PIX; i++) b[i] = BITS'(8'h10 + i);
    applyStimulus(1'b1, 1'b1, 1'b1, b);
    drainAll();

    $display("[TB] back-to-back streaming across frame boundaries");
    dut_eop_count   = 0;
    model_eop_count = 0;
    for (int c = 0; c < 2 * FRAME + N_PIX; c++)
      applyStimulus(1'b1, next_pos == 0, 1'b1, randomBeat());
    drainAll();
    checkOutput("eop count", dut_eop_count, model_eop_count);
    checkOutput("eop per frame", model_eop_count, 2);

    $display("[TB] sof on a mid-frame beat");
    done = 1'b0;
    for (int c = 0; c < 2 * FRAME && !done; c++) begin
      applyStimulus(1'b1, next_pos == TARGET, 1'b1, randomBeat());
      if (last_load && next_pos == N_PIX && bus.sof_in) done = 1'b1;
    end
    checkOutput("mid-frame sof loaded", int'(done), 1);
    drainAll();

    $display("[TB] random valid_in and 50%% output stalls");
    for (int c = 0; c < 800; c++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 1) == 1, randomBeat());
    drainAll();

    $display("[TB] reset after 3 pixels of a beat");
    applyStimulus(1'b1, 1'b0, 1'b1, randomBeat());
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("midreset");
    q.delete();
    next_pos = 0;
    exp_sync = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, randomBeat());
    drainAll();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end
endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Parallel-to-serial pixel stream converter on the output side of the N_PIX-wide processing path. It accepts beats of N_PIX pixels, for example from the ADSR brightness filter, over a valid/ready handshake. It replays them one pixel per clock to the serial video sink and regenerates raster coordinates and start/end-of-frame markers. A single beat buffer allows full serial throughput with no bubbles.

## Interface
Parameters:
- BITS, 8, pixel width
- N_PIX, 8, pixels per input beat; IMAGE_WIDTH must be a multiple of N_PIX
- IMAGE_WIDTH, 640, pixels per line
- IMAGE_HEIGHT, 480, lines per frame

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- pix_in  in  BITS x N_PIX  input beat; element 0 is the leftmost pixel and is emitted first
- valid_in  in  1  pix_in and sof_in are valid
- sof_in  in  1  beat holds the first pixels of a frame (x=0, y=0)
- module_ready  out  1  block can accept a beat this cycle
- pix_out  out  BITS  current serial pixel
- valid_out  out  1  pix_out and its sideband signals are valid
- output_ready  in  1  downstream accepts pix_out this cycle
- pixel_x  out  $clog2(IMAGE_WIDTH)  column of pix_out
- pixel_y  out  $clog2(IMAGE_HEIGHT)  row of pix_out
- sop_out  out  1  high with the pixel at (0,0)
- eop_out  out  1  high with the pixel at (IMAGE_WIDTH-1, IMAGE_HEIGHT-1)
- sync_error  out  1  one-cycle pulse when a sof_in beat is loaded out of position

## Operation
- Storage consists of:
  - a beat register buf[N_PIX];
  - an index idx in 0..N_PIX-1;
  - position counters x and y;
  - a state machine with states EMPTY and DRAIN.
- pix_out = buf[idx]. pixel_x = x and pixel_y = y. valid_out = (state == DRAIN). All outputs are driven from registers, with no combinational path from inputs.
- module_ready = (state == EMPTY) OR (valid_out AND output_ready AND idx == N_PIX-1). This is the only path from an input (output_ready) to an output.
- Load: when valid_in AND module_ready, the block captures buf <= pix_in, sets idx <= 0 and enters DRAIN.
- Serial handshake: when valid_out AND output_ready:
  - idx increments;
  - x/y advance: x+1; at x == IMAGE_WIDTH-1, x wraps to 0 and y increments; at y == IMAGE_HEIGHT-1 with the x wrap, y wraps to 0.
- End of beat: the handshake at idx == N_PIX-1 leads to DRAIN with idx 0 if a load occurs in the same cycle, otherwise to EMPTY.
- Between beats, x/y hold the position of the next pixel to be emitted.
- sof_in on a load:
  - if the held (x,y) != (0,0), sync_error pulses for one cycle;
  - in all cases, x and y are forced to 0 for the new beat, overriding any advance in the same cycle.
- sof_in is ignored when no load occurs.
- sop_out = valid_out AND x == 0 AND y == 0. eop_out = valid_out AND x == IMAGE_WIDTH-1 AND y == IMAGE_HEIGHT-1.
- When output_ready is low, pix_out, pixel_x, pixel_y, sop_out and eop_out hold stable, and no load occurs in DRAIN.

## Timing
- Reset values:
  - valid_out 0, sop_out 0, eop_out 0, sync_error 0;
  - pix_out 0 (buf cleared), pixel_x 0, pixel_y 0;
  - module_ready 1 (state EMPTY), idx 0.
- Reset asserted mid-beat discards any buffered pixels. The first beat after release starts at (0,0) with no sync_error.
- Latency: for a beat accepted at edge k, its pixel 0 is presented with valid_out high from edge k onward. Its pixel N_PIX-1 is presented at the earliest N_PIX-1 cycles later.
- Throughput: with output_ready held high and valid_in always available, valid_out stays continuously 1 and module_ready is high exactly 1 cycle in N_PIX.
- sync_error rises at the edge after the load and lasts one cycle.

## Test plan
- Reset, then one beat {0x10..0x17} with sof_in=1 and output_ready=1 -> pix_out emits 0x10..0x17 on 8 consecutive cycles at x=0..7, y=0; sop_out only on the first of these; module_ready low for 7 cycles, then high; no sync_error.
- Full frame streamed back-to-back -> 307200 pixels with valid_out never dropping; eop_out exactly once at (639,479); the next sof_in beat loads without sync_error.
- Random output_ready stalls (50%) -> output values stable during stalls; pixel order and coordinates identical to the no-stall case.
- sof_in on the beat at x=320, y=5 -> sync_error pulses one cycle; that beat's first pixel is at (0,0) with sop_out=1.
- Reset asserted after 3 pixels of a beat -> all outputs at reset values immediately; after release module_ready=1, and a new beat restarts at (0,0).
- Last-pixel handshake coincident with valid_in -> next beat's pixel 0 appears on the very next cycle; no bubble on valid_out.
